udp_tx_hdr_insert: RTL
======================

Name: udp_tx_hdr_insert

Overview:
- Store-and-forward stage directly downstream of the UDP TX top-level.
- Buffers one complete UDP frame (8-byte header with zeroed length/checksum, then payload) from the UDP TX stream.
- Waits for the computed length/checksum, overwrites header bytes 4-7 on replay, and forwards the frame to the IP TX stage.
- Drops malformed frames and flags them.

Parameters:
- AXI_DATA_WIDTH, 8, stream width in bits; only 8 is supported.
- MAX_PAYLOAD, 1472, max UDP payload bytes; buffer depth = MAX_PAYLOAD+8.
- Localparam ADDR_WIDTH = $clog2(MAX_PAYLOAD+8).

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset
- s_axis_tdata  in  8  UDP frame byte from UDP TX
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  last frame byte
- s_axis_trdy  out  1  input ready
- s_csum_valid  in  1  level; a rising edge marks new length/checksum
- s_udp_length  in  16  UDP length (header + payload)
- s_udp_checksum  in  16  UDP checksum, already complemented
- m_axis_tdata  out  8  frame byte to IP TX
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last frame byte
- m_axis_trdy  in  1  downstream ready
- o_len_err  out  1  one-cycle pulse: frame dropped, length mismatch or frame shorter than 8 bytes
- o_ovf_err  out  1  one-cycle pulse: frame dropped, more than MAX_PAYLOAD+8 bytes
- o_busy  out  1  high whenever not in STORE with byte count 0

Behaviour:
- Reset: i_reset_n is synchronous, active-low, on clock i_clk.
  - All outputs 0; state STORE; byte count 0; checksum-pending flag 0.
  - Edge-detect register resets to 1, so a level held high across reset is not a new event.
  - Reset mid-store or mid-replay discards the frame with no error pulse.
- Checksum capture, any state: on s_csum_valid 0->1, latch length and checksum and set pending.
  - A second edge while pending overwrites the latched values.
  - A captured checksum of 0x0000 is replaced by 0xFFFF.
- State STORE:
  - s_axis_trdy=1.
  - Each accepted byte is written at address = count, then count++.
  - Writes stop at count = MAX_PAYLOAD+8; further bytes are still accepted and discarded, and an overflow flag is set.
  - On accepted tlast:
    - If the overflow flag is set: pulse o_ovf_err next cycle, clear count/pending, stay in STORE.
    - Otherwise: go to WAIT_CSUM.
- State WAIT_CSUM:
  - s_axis_trdy=0.
  - When pending=1, compare the final count with the latched length.
    - If count < 8 or count != length: pulse o_len_err, clear pending/count, go to STORE.
    - Otherwise: clear pending, go to REPLAY.
  - A checksum already pending on entry is evaluated in the entry cycle.
- State REPLAY:
  - s_axis_trdy=0.
  - Read address runs 0..count-1 from the RAM (1-cycle read latency), with an output register plus 1-entry skid.
  - Byte substitution: index 4 = length[15:8], 5 = length[7:0], 6 = checksum[15:8], 7 = checksum[7:0]; all other bytes pass through.
  - First m_axis_tvalid exactly 2 cycles after entering REPLAY.
  - With m_axis_trdy held 1: one byte per cycle, no bubbles.
  - m_axis_tdata/tlast are stable while tvalid=1 and trdy=0.
  - m_axis_tlast on byte count-1.
  - After the last handshake: count=0, go to STORE; s_axis_trdy=1 the following cycle.
- One frame in flight; there is no overlap of store and replay.

Decomposition:
- Package udp_pkg: state enum (STORE, WAIT_CSUM, REPLAY), UDP_HEADER_LENGTH=8, header byte offsets (LEN_HI=4, LEN_LO=5, CSUM_HI=6, CSUM_LO=7).
- Sub-module udp_frame_ram: simple dual-port RAM, 8 bits x 2^ADDR_WIDTH, sync write, registered read.

Test Plan:
- 8-byte header + 4-byte payload AA BB CC DD; edge with length=0x000C, checksum=0x1234 arriving after tlast; trdy=1 -> output is original bytes 0-3, 00 0C 12 34, AA BB CC DD; tlast on byte 12; no stalls.
- Same frame with the checksum edge arriving 3 cycles before input tlast -> identical output; WAIT_CSUM lasts 1 cycle.
- Checksum 0x0000 -> bytes 6-7 out as FF FF.
- 11-byte frame with length=0x000C -> o_len_err pulse, no m_axis_tvalid, next frame accepted normally.
- Frame of MAX_PAYLOAD+9 bytes -> o_ovf_err pulse, no output; random m_axis_trdy (50%) on a 1480-byte frame -> byte-exact output with stable data during stalls.
- Reset asserted at replay byte 5 -> all outputs 0, s_axis_trdy=1 after release, s_csum_valid held high gives no capture until it toggles low then high.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared types and header layout constants for the UDP TX header-insert stage.
package udp_pkg;

    typedef enum logic [1:0] {
        STORE,
        WAIT_CSUM,
        REPLAY
    } state_t;

    localparam int UDP_HEADER_LENGTH = 8;
    localparam int LEN_HI            = 4;
    localparam int LEN_LO            = 5;
    localparam int CSUM_HI           = 6;
    localparam int CSUM_LO           = 7;

    // A transmitted checksum of zero means "no checksum" in UDP, so zero is sent as all-ones.
    function automatic logic [15:0] fix_csum(input logic [15:0] csum);
        return (csum == 16'h0000) ? 16'hFFFF : csum;
    endfunction

endpackage

// File: rtl/udp_frame_ram.sv
// Simple dual-port frame buffer: synchronous write, registered read (1-cycle latency).
module udp_frame_ram #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge i_clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/udp_tx_hdr_insert.sv
// Store-and-forward UDP frame buffer that patches length/checksum into header bytes 4-7 on replay.
// First output byte 2 cycles after replay starts; output register + 1-entry skid absorbs m_axis_trdy stalls.
module udp_tx_hdr_insert
    import udp_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 8,
    parameter int MAX_PAYLOAD    = 1472
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_trdy,
    input  logic                      s_csum_valid,
    input  logic [15:0]               s_udp_length,
    input  logic [15:0]               s_udp_checksum,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_trdy,
    output logic                      o_len_err,
    output logic                      o_ovf_err,
    output logic                      o_busy
);
    localparam int ADDR_WIDTH = $clog2(MAX_PAYLOAD + UDP_HEADER_LENGTH);
    localparam int CNT_W      = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] FRAME_MAX = CNT_W'(MAX_PAYLOAD + UDP_HEADER_LENGTH);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t                    state_q;
    logic [CNT_W-1:0]          count_q, rd_addr_q, rd_idx_q;
    logic                      ovf_q, pending_q, csum_prev_q, in_rdy_q;
    logic [15:0]               len_q, csum_q, rp_len_q, rp_csum_q;
    logic                      rd_vld_q, out_vld_q, out_last_q, skid_vld_q, skid_last_q;
    logic [AXI_DATA_WIDTH-1:0] out_dat_q, skid_dat_q;
    logic                      len_err_q, ovf_err_q;

    logic                      acc, csum_rise, pop, issue, ovf_now, len_bad, rd_last;
    logic [1:0]                held;
    logic [AXI_DATA_WIDTH-1:0] ram_rd_dat, rd_sub_dat;

    assign acc       = s_axis_tvalid & in_rdy_q;
    assign csum_rise = s_csum_valid & ~csum_prev_q;
    assign ovf_now   = ovf_q | (count_q == FRAME_MAX);
    assign len_bad   = (count_q < CNT_W'(UDP_HEADER_LENGTH)) || (16'(count_q) != len_q);
    assign pop       = out_vld_q & m_axis_trdy;
    // Bytes that will still occupy out/skid next cycle; a read is only issued if a slot is guaranteed.
    assign held      = 2'(out_vld_q & ~pop) + 2'(skid_vld_q) + 2'(rd_vld_q);
    assign issue     = (state_q == REPLAY) && (rd_addr_q < count_q) && (held < 2'd2);
    assign rd_last   = (rd_idx_q + ONE) == count_q;

    udp_frame_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(AXI_DATA_WIDTH)) u_ram (
        .i_clk     (i_clk),
        .wr_en_i   (acc && (count_q < FRAME_MAX)),
        .wr_addr_i (count_q[ADDR_WIDTH-1:0]),
        .wr_data_i (s_axis_tdata),
        .rd_en_i   (issue),
        .rd_addr_i (rd_addr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (ram_rd_dat)
    );

    always_comb begin
        rd_sub_dat = ram_rd_dat;
        if      (rd_idx_q == CNT_W'(LEN_HI))  rd_sub_dat = rp_len_q[15:8];
        else if (rd_idx_q == CNT_W'(LEN_LO))  rd_sub_dat = rp_len_q[7:0];
        else if (rd_idx_q == CNT_W'(CSUM_HI)) rd_sub_dat = rp_csum_q[15:8];
        else if (rd_idx_q == CNT_W'(CSUM_LO)) rd_sub_dat = rp_csum_q[7:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= STORE;
            count_q     <= '0;
            rd_addr_q   <= '0;
            rd_idx_q    <= '0;
            ovf_q       <= 1'b0;
            pending_q   <= 1'b0;
            csum_prev_q <= 1'b1;
            in_rdy_q    <= 1'b0;
            len_q       <= '0;
            csum_q      <= '0;
            rp_len_q    <= '0;
            rp_csum_q   <= '0;
            rd_vld_q    <= 1'b0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_dat_q   <= '0;
            skid_vld_q  <= 1'b0;
            skid_last_q <= 1'b0;
            skid_dat_q  <= '0;
            len_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            csum_prev_q <= s_csum_valid;
            len_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;

            unique case (state_q)
                STORE: begin
                    in_rdy_q <= 1'b1;
                    if (acc) begin
                        if (count_q < FRAME_MAX) count_q <= count_q + ONE;
                        else                     ovf_q   <= 1'b1;
                        if (s_axis_tlast) begin
                            if (ovf_now) begin
                                ovf_err_q <= 1'b1;
                                ovf_q     <= 1'b0;
                                count_q   <= '0;
                                pending_q <= 1'b0;
                            end else begin
                                state_q  <= WAIT_CSUM;
                                in_rdy_q <= 1'b0;
                            end
                        end
                    end
                end

                WAIT_CSUM: begin
                    if (pending_q) begin
                        pending_q <= 1'b0;
                        if (len_bad) begin
                            len_err_q <= 1'b1;
                            count_q   <= '0;
                            state_q   <= STORE;
                            in_rdy_q  <= 1'b1;
                        end else begin
                            rp_len_q  <= len_q;
                            rp_csum_q <= csum_q;
                            rd_addr_q <= '0;
                            state_q   <= REPLAY;
                        end
                    end
                end

                REPLAY: begin
                    if (issue) rd_addr_q <= rd_addr_q + ONE;
                    rd_vld_q <= issue;
                    rd_idx_q <= rd_addr_q;

                    if (!out_vld_q || pop) begin
                        if (skid_vld_q) begin
                            out_vld_q   <= 1'b1;
                            out_dat_q   <= skid_dat_q;
                            out_last_q  <= skid_last_q;
                            skid_vld_q  <= rd_vld_q;
                            skid_dat_q  <= rd_sub_dat;
                            skid_last_q <= rd_last;
                        end else if (rd_vld_q) begin
                            out_vld_q  <= 1'b1;
                            out_dat_q  <= rd_sub_dat;
                            out_last_q <= rd_last;
                        end else begin
                            out_vld_q  <= 1'b0;
                            out_last_q <= 1'b0;
                        end
                    end else if (rd_vld_q) begin
                        skid_vld_q  <= 1'b1;
                        skid_dat_q  <= rd_sub_dat;
                        skid_last_q <= rd_last;
                    end

                    if (pop && out_last_q) begin
                        count_q   <= '0;
                        rd_addr_q <= '0;
                        state_q   <= STORE;
                        in_rdy_q  <= 1'b1;
                    end
                end

                default: state_q <= STORE;
            endcase

            // A new length/checksum edge wins over any same-cycle clear of the pending flag.
            if (csum_rise) begin
                len_q     <= s_udp_length;
                csum_q    <= fix_csum(s_udp_checksum);
                pending_q <= 1'b1;
            end
        end
    end

    assign s_axis_trdy   = in_rdy_q;
    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tdata  = out_dat_q;
    assign m_axis_tlast  = out_last_q;
    assign o_len_err     = len_err_q;
    assign o_ovf_err     = ovf_err_q;
    assign o_busy        = !((state_q == STORE) && (count_q == '0));

endmodule
